// File: rtl/contador_mod_ajustable.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : contador_mod_ajustable                                        |
// | Purpose  : Modulo-MODULUS up/down counter for clock/timer digits. Counts |
// |            up on a timebase tick, steps once per button press, supports |
// |            synchronous clear/load and emits a carry pulse on tick wrap  |
// |            so several instances can be cascaded (sec -> min -> hour).   |
// | Optional : define HOLD_REPEAT_EN to add auto-repeat of a held button    |
// |            (REPEAT_DELAY cycles to first repeat, then every            |
// |            REPEAT_PERIOD cycles).                                      |
// | Ports    : clk        - system clock, rising edge                       |
// |            rst_n      - asynchronous active-low reset                   |
// |            tick       - 1-cycle timebase pulse, count up one step       |
// |            btn_inc    - increment button level (clean, synchronous)     |
// |            btn_dec    - decrement button level (clean, synchronous)     |
// |            clear      - synchronous clear to 0                          |
// |            load       - synchronous load strobe                         |
// |            load_value - value loaded (clamped to MODULUS-1)             |
// |            count      - registered count                                |
// |            carry_out  - 1-cycle pulse on tick-driven MODULUS-1 -> 0     |
// |            at_max     - combinational, count == MODULUS-1               |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module contador_mod_ajustable #(
  parameter int MODULUS       = 60,
  parameter int WIDTH         = 6,
  parameter int REPEAT_DELAY  = 500,
  parameter int REPEAT_PERIOD = 100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             btn_inc,
  input  logic             btn_dec,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             carry_out,
  output logic             at_max
);

  localparam logic [WIDTH-1:0] C_MAX = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             carry_q, carry_d;
  logic             inc_hist_q, dec_hist_q;
  logic             inc_ev, dec_ev;
  logic             step_up, step_dn;

  // Histories reset to 1 so a button held through reset release is not a press.
  assign inc_ev = btn_inc & ~inc_hist_q;
  assign dec_ev = btn_dec & ~dec_hist_q;

`ifdef HOLD_REPEAT_EN
  localparam int C_RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int C_CW   = (C_RMAX > 1) ? $clog2(C_RMAX) : 1;
  localparam logic [C_CW-1:0] C_DLY_LAST = C_CW'(REPEAT_DELAY - 1);
  localparam logic [C_CW-1:0] C_PER_LAST = C_CW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rep_state_t;

  rep_state_t      rep_state_q;
  logic [C_CW-1:0] rep_cnt_q;
  logic            rep_up_q;     // direction of the button being repeated
  logic            held_alone;
  logic            rep_step;

  assign held_alone = rep_up_q ? (btn_inc & ~btn_dec) : (btn_dec & ~btn_inc);

  assign rep_step = held_alone &
                    (((rep_state_q == ST_DELAY)  && (rep_cnt_q == C_DLY_LAST)) ||
                     ((rep_state_q == ST_REPEAT) && (rep_cnt_q == C_PER_LAST)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_state_q <= ST_IDLE;
      rep_cnt_q   <= '0;
      rep_up_q    <= 1'b0;
    end else if (clear || load) begin
      rep_state_q <= ST_IDLE;
      rep_cnt_q   <= '0;
    end else if (inc_ev ^ dec_ev) begin
      // A fresh single press (re)starts the hold delay in its own direction.
      rep_state_q <= ST_DELAY;
      rep_cnt_q   <= '0;
      rep_up_q    <= inc_ev;
    end else begin
      case (rep_state_q)
        ST_DELAY: begin
          if (!held_alone) begin
            rep_state_q <= ST_IDLE;
          end else if (rep_cnt_q == C_DLY_LAST) begin
            rep_state_q <= ST_REPEAT;
            rep_cnt_q   <= '0;
          end else begin
            rep_cnt_q <= rep_cnt_q + 1'b1;
          end
        end
        ST_REPEAT: begin
          if (!held_alone) begin
            rep_state_q <= ST_IDLE;
          end else if (rep_cnt_q == C_PER_LAST) begin
            rep_cnt_q <= '0;
          end else begin
            rep_cnt_q <= rep_cnt_q + 1'b1;
          end
        end
        default: rep_state_q <= ST_IDLE;
      endcase
    end
  end

  assign step_up = (inc_ev & ~dec_ev) | (rep_step &  rep_up_q);
  assign step_dn = (dec_ev & ~inc_ev) | (rep_step & ~rep_up_q);
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = (REPEAT_DELAY > REPEAT_PERIOD);

  assign step_up = inc_ev & ~dec_ev;
  assign step_dn = dec_ev & ~inc_ev;
`endif

  always_comb begin
    count_d = count_q;
    carry_d = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = (load_value > C_MAX) ? C_MAX : load_value;
    end else if (inc_ev || dec_ev || step_up || step_dn) begin
      // Any button activity swallows the tick; simultaneous inc+dec is a no-op.
      if (step_up) begin
        count_d = (count_q == C_MAX) ? '0 : count_q + 1'b1;
      end else if (step_dn) begin
        count_d = (count_q == '0) ? C_MAX : count_q - 1'b1;
      end
    end else if (tick) begin
      if (count_q == C_MAX) begin
        count_d = '0;
        carry_d = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      carry_q    <= 1'b0;
      inc_hist_q <= 1'b1;
      dec_hist_q <= 1'b1;
    end else begin
      count_q    <= count_d;
      carry_q    <= carry_d;
      inc_hist_q <= btn_inc;
      dec_hist_q <= btn_dec;
    end
  end

  assign count     = count_q;
  assign carry_out = carry_q;
  assign at_max    = (count_q == C_MAX);

endmodule
`default_nettype wire

// File: tb/tb_contador_mod_ajustable.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_contador_mod_ajustable                                     |
// | Purpose  : Directed self-checking bench for contador_mod_ajustable       |
// |            (MODULUS=60, WIDTH=6, REPEAT_DELAY=5, REPEAT_PERIOD=2).       |
// |            Expectations adapt when HOLD_REPEAT_EN is defined.           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_contador_mod_ajustable;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic       btn_inc;
  logic       btn_dec;
  logic       clear;
  logic       load;
  logic [5:0] load_value;
  logic [5:0] count;
  logic       carry_out;
  logic       at_max;

  int n_vec;
  int n_err;

  contador_mod_ajustable #(
    .MODULUS      (60),
    .WIDTH        (6),
    .REPEAT_DELAY (5),
    .REPEAT_PERIOD(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .btn_inc   (btn_inc),
    .btn_dec   (btn_dec),
    .clear     (clear),
    .load      (load),
    .load_value(load_value),
    .count     (count),
    .carry_out (carry_out),
    .at_max    (at_max)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit before sampling/driving.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_v;
    n_vec      = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    tick       = 1'b0;
    btn_inc    = 1'b1;   // held through reset release
    btn_dec    = 1'b0;
    clear      = 1'b0;
    load       = 1'b0;
    load_value = '0;

    cyc();
    cyc();
    check("reset_count", count, 0);
    check("reset_carry", carry_out, 0);
    check("reset_at_max", at_max, 0);

    rst_n = 1'b1;
    cyc();
    check("held_btn_no_step", count, 0);
    btn_inc = 1'b0;
    cyc();
    check("held_btn_release", count, 0);

    // 60 ticks: 0..59 then wrap with a single carry pulse
    tick = 1'b1;
    for (int i = 1; i < 60; i++) begin
      cyc();
      check("tick_count", count, i);
      check("tick_no_carry", carry_out, 0);
    end
    check("at_max_59", at_max, 1);
    cyc();
    check("wrap_count", count, 0);
    check("wrap_carry", carry_out, 1);
    check("wrap_at_max", at_max, 0);
    tick = 1'b0;
    cyc();
    check("carry_one_cycle", carry_out, 0);

    // btn_dec held 10 cycles from 0
    btn_dec = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cyc();
`ifdef HOLD_REPEAT_EN
      exp_v = 59 - int'(k >= 5) - int'(k >= 7) - int'(k >= 9);
`else
      exp_v = 59;
`endif
      check("dec_hold_count", count, exp_v);
      check("dec_hold_carry", carry_out, 0);
    end
    btn_dec = 1'b0;
    load = 1'b1;
    load_value = 6'd59;
    cyc();
    load = 1'b0;
    check("load_59", count, 59);

    // btn_inc edge together with tick at 59: button wins, no carry
    btn_inc = 1'b1;
    tick    = 1'b1;
    cyc();
    check("inc_tick_count", count, 0);
    check("inc_tick_carry", carry_out, 0);
    btn_inc = 1'b0;
    tick    = 1'b0;
    cyc();
    check("inc_tick_after", carry_out, 0);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    check("next_tick", count, 1);

    // inc+dec together (with tick) from 30: no change
    load = 1'b1;
    load_value = 6'd30;
    cyc();
    load = 1'b0;
    check("load_30", count, 30);
    btn_inc = 1'b1;
    btn_dec = 1'b1;
    tick    = 1'b1;
    cyc();
    check("inc_dec_same", count, 30);
    btn_inc = 1'b0;
    btn_dec = 1'b0;
    tick    = 1'b0;
    cyc();
    check("inc_dec_hold", count, 30);

    // load clamp, then clear beats load
    load = 1'b1;
    load_value = 6'd63;
    cyc();
    check("load_clamp", count, 59);
    check("load_clamp_at_max", at_max, 1);
    clear = 1'b1;
    load_value = 6'd5;
    cyc();
    clear = 1'b0;
    load  = 1'b0;
    check("clear_over_load", count, 0);

    // asynchronous reset mid-count at 42
    load = 1'b1;
    load_value = 6'd42;
    cyc();
    load = 1'b0;
    check("load_42", count, 42);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset", count, 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    check("after_reset", count, 0);

    // btn_inc held 12 cycles from 10
    load = 1'b1;
    load_value = 6'd10;
    cyc();
    load = 1'b0;
    check("load_10", count, 10);
    btn_inc = 1'b1;
    for (int k = 0; k < 12; k++) begin
      cyc();
`ifdef HOLD_REPEAT_EN
      exp_v = 11 + int'(k >= 5) + int'(k >= 7) + int'(k >= 9) + int'(k >= 11);
`else
      exp_v = 11;
`endif
      check("inc_hold_count", count, exp_v);
    end
    btn_inc = 1'b0;
`ifdef HOLD_REPEAT_EN
    exp_v = 15;
`else
    exp_v = 11;
`endif
    for (int k = 0; k < 4; k++) begin
      cyc();
      check("release_hold", count, exp_v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Watchdog so the bench cannot hang.
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
